// File: rtl/image_batch_streamer.sv
// image_batch_streamer: streams a batch of stored images over valid/ready and scores
// the classifier results that come back against stored labels.
module image_batch_streamer #(
    parameter int DATA_W     = 8,
    parameter int IMG_PIXELS = 784,
    parameter int NUM_IMAGES = 4,
    parameter int CLASS_W    = 4,
    parameter int CONF_W     = 8,
    parameter int TIMEOUT    = 2000,
    parameter int IMG_GAP    = 0,
    localparam int AW = $clog2(NUM_IMAGES * IMG_PIXELS),
    localparam int IW = $clog2(NUM_IMAGES) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mem_we,
    input  logic [AW-1:0]      mem_addr,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               label_we,
    input  logic [IW-1:0]      label_idx,
    input  logic [CLASS_W-1:0] label_wdata,
    output logic [DATA_W-1:0]  pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    input  logic               res_valid,
    input  logic [CLASS_W-1:0] res_class,
    input  logic [CONF_W-1:0]  res_conf,
    output logic               busy,
    output logic               done,
    output logic [IW-1:0]      img_idx,
    output logic [IW-1:0]      correct_cnt,
    output logic [IW-1:0]      timeout_cnt,
    output logic [CLASS_W-1:0] last_class,
    output logic [CONF_W-1:0]  last_conf,
    output logic               last_match
);
    localparam int PW   = $clog2(IMG_PIXELS + 1);
    localparam int TMAX = TIMEOUT > IMG_GAP ? TIMEOUT : IMG_GAP;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, STREAM, WAIT_RES, GAP, DONE} state_t;

    state_t state_q, state_d;
    logic [DATA_W-1:0]  mem [NUM_IMAGES*IMG_PIXELS];
    logic [CLASS_W-1:0] labels [2**IW];
    logic [IW-1:0]      img_idx_q, img_idx_d, correct_q, correct_d, timeout_q, timeout_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic [PW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]  pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic [CLASS_W-1:0] last_class_q, last_class_d;
    logic [CONF_W-1:0]  last_conf_q, last_conf_d;
    logic               last_match_q, last_match_d;
    logic               match, finish, step;

    always_ff @(posedge clk) begin
        if (mem_we && state_q == IDLE) mem[mem_addr] <= mem_wdata;
        if (label_we && state_q == IDLE) labels[label_idx] <= label_wdata;
    end

    assign match = res_class == labels[img_idx_q];

    always_comb begin
        state_d      = state_q;
        img_idx_d    = img_idx_q;
        correct_d    = correct_q;
        timeout_d    = timeout_q;
        rd_addr_d    = rd_addr_q;
        pix_cnt_d    = pix_cnt_q;
        cnt_d        = cnt_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        last_class_d = last_class_q;
        last_conf_d  = last_conf_q;
        last_match_d = last_match_q;
        finish       = 1'b0;
        step         = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d      = STREAM;
                img_idx_d    = '0;
                rd_addr_d    = '0;
                pix_cnt_d    = '0;
                correct_d    = '0;
                timeout_d    = '0;
                last_class_d = '0;
                last_conf_d  = '0;
                last_match_d = 1'b0;
            end
            // Output register refills whenever it is empty or being drained, so no bubbles.
            STREAM: if (!pix_valid_q || pix_ready) begin
                if (pix_cnt_q != PW'(IMG_PIXELS)) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = mem[rd_addr_q];
                    rd_addr_d   = rd_addr_q + AW'(1);
                    pix_cnt_d   = pix_cnt_q + PW'(1);
                end else begin
                    pix_valid_d = 1'b0;
                    state_d     = WAIT_RES;
                    cnt_d       = '0;
                end
            end
            WAIT_RES: if (res_valid) begin
                last_class_d = res_class;
                last_conf_d  = res_conf;
                last_match_d = match;
                correct_d    = correct_q + IW'(match);
                finish       = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                timeout_d    = timeout_q + IW'(1);
                last_match_d = 1'b0;
                finish       = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            GAP: if (cnt_q == CW'(IMG_GAP - 1)) step = 1'b1;
                 else cnt_d = cnt_q + CW'(1);
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (finish) begin
            cnt_d = '0;
            if (IMG_GAP == 0) step = 1'b1;
            else state_d = GAP;
        end
        if (step) begin
            cnt_d     = '0;
            pix_cnt_d = '0;
            if (img_idx_q == IW'(NUM_IMAGES - 1)) state_d = DONE;
            else begin
                img_idx_d = img_idx_q + IW'(1);
                state_d   = STREAM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            img_idx_q    <= '0;
            correct_q    <= '0;
            timeout_q    <= '0;
            rd_addr_q    <= '0;
            pix_cnt_q    <= '0;
            cnt_q        <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            last_class_q <= '0;
            last_conf_q  <= '0;
            last_match_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            img_idx_q    <= img_idx_d;
            correct_q    <= correct_d;
            timeout_q    <= timeout_d;
            rd_addr_q    <= rd_addr_d;
            pix_cnt_q    <= pix_cnt_d;
            cnt_q        <= cnt_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            last_class_q <= last_class_d;
            last_conf_q  <= last_conf_d;
            last_match_q <= last_match_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign img_idx     = img_idx_q;
    assign correct_cnt = correct_q;
    assign timeout_cnt = timeout_q;
    assign last_class  = last_class_q;
    assign last_conf   = last_conf_q;
    assign last_match  = last_match_q;
endmodule

// File: tb/tb_image_batch_streamer.sv
// tb_image_batch_streamer: table of batch scenarios checked against a pixel scoreboard,
// plus hand-written reset and start/write corner sequences.
module tb_image_batch_streamer;
    localparam int P = 784, N = 4, TO = 50, GP = 3;

    logic        clk = 0, rst_n = 1;
    logic        start = 0, mem_we = 0, label_we = 0, pix_ready = 0, res_valid = 0;
    logic [11:0] mem_addr = 0;
    logic [7:0]  mem_wdata = 0, pix_data, res_conf = 0;
    logic [2:0]  label_idx = 0, img_idx, correct_cnt, timeout_cnt;
    logic [3:0]  label_wdata = 0, res_class = 0, last_class;
    logic [7:0]  last_conf;
    logic        pix_valid, busy, done, last_match;

    always #5 clk = ~clk;

    image_batch_streamer #(
        .DATA_W(8), .IMG_PIXELS(P), .NUM_IMAGES(N), .CLASS_W(4), .CONF_W(8),
        .TIMEOUT(TO), .IMG_GAP(GP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .label_we(label_we), .label_idx(label_idx),
        .label_wdata(label_wdata), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .res_valid(res_valid), .res_class(res_class),
        .res_conf(res_conf), .busy(busy), .done(done), .img_idx(img_idx),
        .correct_cnt(correct_cnt), .timeout_cnt(timeout_cnt), .last_class(last_class),
        .last_conf(last_conf), .last_match(last_match)
    );

    typedef struct {
        logic [15:0] cls;
        logic [31:0] conf;
        logic [3:0]  resp;
        int          delay;
        bit          rnd_ready, noise, poke;
        logic [7:0]  pix0;
        int          exp_correct, exp_timeout;
    } vec_t;

    int         vectors = 0, miscompares = 0;
    logic [7:0] exp_mem [N*P];
    logic [3:0] lbl [N];
    logic [7:0] sb_q [$];
    vec_t       vt [6];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero();
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_img_idx", img_idx, 0);
        chk("rst_correct", correct_cnt, 0);
        chk("rst_timeout", timeout_cnt, 0);
        chk("rst_last_class", last_class, 0);
        chk("rst_last_conf", last_conf, 0);
        chk("rst_last_match", last_match, 0);
    endtask

    task automatic run_batch(input vec_t v);
        int xfers = 0, img_first = 0, last_xfer_it = -1000, resp_it = -1000;
        int resp_img = 0, prev_to = 0;
        bit prev_stall = 0, got_done = 0;
        logic [7:0] prev_data = 0;
        logic [3:0] rc;
        exp_mem[0] = v.pix0;
        sb_q.delete();
        for (int a = 0; a < N * P; a++) sb_q.push_back(exp_mem[a]);
        @(negedge clk);
        start = 1; mem_we = 1; mem_addr = 0; mem_wdata = v.pix0;
        @(negedge clk);
        start = 0; mem_we = 0;
        chk("start_busy", busy, 1);
        chk("start_clr_correct", correct_cnt, 0);
        chk("start_clr_timeout", timeout_cnt, 0);
        chk("start_clr_img", img_idx, 0);
        chk("start_clr_last_class", last_class, 0);
        chk("start_clr_last_conf", last_conf, 0);
        for (int it = 1; it < 20000; it++) begin
            if (it > 1) @(negedge clk);
            pix_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            res_valid = 0;
            if (it == resp_it) begin
                res_valid = 1;
                res_class = v.cls[4*resp_img +: 4];
                res_conf  = v.conf[8*resp_img +: 8];
            end else if (v.noise && pix_valid && xfers < N * P && xfers % P >= 10
                         && xfers % P <= 700 && it % 37 == 0) begin
                res_valid = 1;
                res_class = lbl[xfers / P];
                res_conf  = 8'hEE;
            end
            start = 0; mem_we = 0;
            if (v.poke && it == 100) begin
                start = 1; mem_we = 1; mem_addr = 3000; mem_wdata = ~exp_mem[3000];
            end
            if (it == 2) chk("first_valid_latency", pix_valid, 1);
            if (prev_stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_data", pix_data, prev_data);
            end
            if (pix_valid && pix_ready) begin
                if (sb_q.size() == 0) chk("pixel_overrun", xfers + 1, N * P);
                else chk("pixel", pix_data, sb_q.pop_front());
                chk("stream_img_idx", img_idx, xfers / P);
                if (xfers % P == 0) img_first = it;
                if (xfers % P == P - 1) begin
                    if (!v.rnd_ready) chk("no_bubble", it - img_first, P - 1);
                    last_xfer_it = it;
                    resp_img = xfers / P;
                    resp_it = v.resp[resp_img] ? it + v.delay : -1000;
                end
                xfers++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            if (it == resp_it + 1) begin
                rc = v.cls[4*resp_img +: 4];
                chk("gap_last_class", last_class, rc);
                chk("gap_last_conf", last_conf, v.conf[8*resp_img +: 8]);
                chk("gap_last_match", last_match, int'(rc == lbl[resp_img]));
                chk("gap_pix_valid", pix_valid, 0);
            end
            if (timeout_cnt != 3'(prev_to)) begin
                chk("timeout_latency", it - last_xfer_it, TO + 1);
                chk("timeout_last_match", last_match, 0);
            end
            prev_to = timeout_cnt;
            if (done) begin
                got_done = 1;
                chk("done_correct", correct_cnt, v.exp_correct);
                chk("done_timeout", timeout_cnt, v.exp_timeout);
                chk("done_img_idx", img_idx, N - 1);
                chk("done_last_match", last_match,
                    int'(v.resp[N-1] && v.cls[4*(N-1) +: 4] == lbl[N-1]));
                res_valid = 0;
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("busy_after_done", busy, 0);
                chk("pixels_delivered", xfers, N * P);
                chk("hold_correct", correct_cnt, v.exp_correct);
                break;
            end
        end
        res_valid = 0; start = 0; mem_we = 0;
        chk("done_seen", got_done, 1);
    endtask

    initial begin
        int xfers;
        lbl = '{4'd1, 4'd2, 4'd3, 4'd4};
        vt[0] = '{16'h4321, 32'h44332211, 4'hF, 10, 0, 0, 0, 8'h00, 4, 0};
        vt[1] = '{16'h4721, 32'h40C82010, 4'hF, 10, 0, 0, 0, 8'h5A, 3, 0};
        vt[2] = '{16'h4321, 32'h00000000, 4'h0, 10, 0, 0, 0, 8'h11, 0, 4};
        vt[3] = '{16'h4321, 32'h01020304, 4'hF, 10, 1, 0, 0, 8'h22, 4, 0};
        vt[4] = '{16'h4321, 32'h55667788, 4'hF, 50, 0, 1, 0, 8'h33, 4, 0};
        vt[5] = '{16'h4329, 32'h99AABBCC, 4'h5, 10, 1, 0, 1, 8'h00, 1, 2};

        #2 rst_n = 0;
        #1 check_zero();
        @(negedge clk) rst_n = 1;
        for (int a = 0; a < N * P; a++) begin
            @(negedge clk);
            mem_we = 1; mem_addr = 12'(a); mem_wdata = 8'(a);
            exp_mem[a] = 8'(a);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            mem_we = 0; label_we = 1; label_idx = 3'(i); label_wdata = lbl[i];
        end
        @(negedge clk) label_we = 0;

        for (int s = 0; s < 6; s++) run_batch(vt[s]);

        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        pix_ready = 1;
        xfers = 0;
        for (int it = 0; it < 3000 && xfers < P + 300; it++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) xfers++;
        end
        chk("pre_reset_img_idx", img_idx, 1);
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 0;
        #1 check_zero();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_valid", pix_valid, 0);
        run_batch(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
